// File: rtl/tlb_wr_ctrl_if.sv
// Command / RAM port A bundle for tlb_wr_ctrl.
//   master : register block side; drives the staged entry, row, way and command,
//            and observes handshake/status plus the port A drive.
//   slave  : the write sequencer itself.
// Signals:
//   hold_entry, hold_entry_no, hold_way, cmd_valid, cmd  -> staged command
//   cmd_ready, busy, done, err, rd_dly                   <- handshake / status
//   addra, dina, wea                                     <- RAM port A
interface tlb_wr_ctrl_if #(
  parameter int unsigned TLB_ASSOC   = 4,
  parameter int unsigned TLB_ENTRIES = 1024,
  parameter int unsigned ENTRY_W     = 128
);
  localparam int unsigned AW = $clog2(TLB_ENTRIES);

  typedef logic [ENTRY_W-1:0] tlb_entry_t;

  tlb_entry_t           hold_entry;
  logic [15:0]          hold_entry_no;
  logic [7:0]           hold_way;
  logic                 cmd_valid;
  logic [1:0]           cmd;
  logic                 cmd_ready;
  logic [AW-1:0]        addra;
  tlb_entry_t           dina;
  logic [TLB_ASSOC-1:0] wea;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 rd_dly;

  modport master (
    output hold_entry, hold_entry_no, hold_way, cmd_valid, cmd,
    input  cmd_ready, addra, dina, wea, busy, done, err, rd_dly
  );

  modport slave (
    input  hold_entry, hold_entry_no, hold_way, cmd_valid, cmd,
    output cmd_ready, addra, dina, wea, busy, done, err, rd_dly
  );
endinterface

// File: rtl/tlb_wr_ctrl.sv
// TLB write / maintenance sequencer.
// Takes the entry, row and way staged by software plus a command strobe and
// drives TLB way-RAM port A for a single-entry write, a single-entry
// invalidate, or a full invalidate-all sweep. While idle, port A's address
// follows the staged row and rd_dly tells the bus interface when readback
// data has settled.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous active-low reset
//   bus  - tlb_wr_ctrl_if.slave (staged command in; status and port A out)
module tlb_wr_ctrl #(
  parameter int unsigned TLB_ASSOC   = 4,
  parameter int unsigned TLB_ENTRIES = 1024,
  parameter int unsigned RAM_LAT     = 2,
  parameter int unsigned ENTRY_W     = 128
) (
  input  logic         clk,
  input  logic         rst,
  tlb_wr_ctrl_if.slave bus
);

  localparam int unsigned AW = $clog2(TLB_ENTRIES);
  localparam int unsigned WW = $clog2(TLB_ASSOC);
  localparam int unsigned CW = $clog2(RAM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    SWEEP,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        addra_q, addra_d;
  logic [ENTRY_W-1:0]   dina_q, dina_d;
  logic [TLB_ASSOC-1:0] wea_q, wea_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 rd_dly_q, rd_dly_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [15:0]          lfsr_q, lfsr_d;

  logic                 row_oor;
  logic                 way_in_range;
  logic                 reject;
  logic [WW-1:0]        way_idx;

  always_comb begin
    row_oor      = 32'(bus.hold_entry_no) >= TLB_ENTRIES;
    way_in_range = 32'(bus.hold_way) < TLB_ASSOC;
    reject       = (bus.cmd == 2'd3) || ((bus.cmd != 2'd2) && row_oor);
    // Out-of-range way on a write falls back to the pseudo-random replacement way
    way_idx      = way_in_range ? bus.hold_way[WW-1:0] : lfsr_q[WW-1:0];
  end

  always_comb begin
    state_d = state_q;
    addra_d = addra_q;
    dina_d  = dina_q;
    wea_d   = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    // Port A controls are registered on entry to each state, so everything
    // the command needs is captured on the accepting edge.
    unique case (state_q)
      IDLE: begin
        addra_d = bus.hold_entry_no[AW-1:0];
        if (bus.cmd_valid) begin
          if (reject) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (bus.cmd == 2'd2) begin
            state_d = SWEEP;
            addra_d = '0;
            dina_d  = '0;
            wea_d   = '1;
          end else begin
            state_d = WRITE;
            if (bus.cmd == 2'd0) begin
              dina_d         = bus.hold_entry;
              wea_d[way_idx] = 1'b1;
            end else begin
              dina_d = '0;
              if (way_in_range) wea_d[way_idx] = 1'b1;
              else              wea_d          = '1;
            end
          end
        end
      end
      WRITE: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      SWEEP: begin
        if (addra_q == AW'(TLB_ENTRIES - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          addra_d = addra_q + AW'(1);
          wea_d   = '1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_q != IDLE) || (addra_d != addra_q)) cnt_d = '0;
    else if (cnt_q == CW'(RAM_LAT))                 cnt_d = cnt_q;
    else                                            cnt_d = cnt_q + CW'(1);

    // Registered from next-state values so rd_dly equals (cnt == RAM_LAT) & IDLE
    rd_dly_d = (cnt_d == CW'(RAM_LAT)) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addra_q  <= '0;
      dina_q   <= '0;
      wea_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_dly_q <= 1'b0;
      cnt_q    <= '0;
      lfsr_q   <= 16'hACE1;
    end else begin
      state_q  <= state_d;
      addra_q  <= addra_d;
      dina_q   <= dina_d;
      wea_q    <= wea_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rd_dly_q <= rd_dly_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.addra     = addra_q;
  assign bus.dina      = dina_q;
  assign bus.wea       = wea_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rd_dly    = rd_dly_q;

endmodule

// File: tb/tb_tlb_wr_ctrl.sv
// Bench for tlb_wr_ctrl: directed scenarios from the command set plus a
// randomized command stream checked against a behavioural model.
module tb_tlb_wr_ctrl;

  localparam int ASSOC   = 4;
  localparam int ENTRIES = 16;
  localparam int LAT     = 2;
  localparam int EW      = 128;
  localparam int AW      = $clog2(ENTRIES);
  localparam int WB      = $clog2(ASSOC);

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  tlb_wr_ctrl_if #(.TLB_ASSOC(ASSOC), .TLB_ENTRIES(ENTRIES), .ENTRY_W(EW)) bus ();

  tlb_wr_ctrl #(
    .TLB_ASSOC  (ASSOC),
    .TLB_ENTRIES(ENTRIES),
    .RAM_LAT    (LAT),
    .ENTRY_W    (EW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference replacement generator: 16-bit Fibonacci LFSR, taps 16,14,13,11,
  // seeded 0xACE1, stepping once per clock outside reset.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 16'hACE1;
    else      m_lfsr <= (m_lfsr >> 1) |
                        (((m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'd1) << 15);
  end

  function automatic logic [ASSOC-1:0] exp_wea(input int c, input int no, input int way,
                                              input logic [15:0] lf);
    logic [ASSOC-1:0] r;
    int k;
    r = '0;
    if (c == 3 || (c < 2 && no >= ENTRIES)) return r;
    if (c == 2 || (c == 1 && way >= ASSOC)) return '1;
    k = (way < ASSOC) ? way : int'(lf) % ASSOC;
    r[k[WB-1:0]] = 1'b1;
    return r;
  endfunction

  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.cmd = 2'd0; bus.hold_entry = '0;
    bus.hold_entry_no = 16'd0; bus.hold_way = 8'd0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.wea, bus.addra, bus.dina, bus.done, bus.err, bus.rd_dly} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: wea=%b addra=%0d dina=%h done=%b err=%b rd_dly=%b, want all zero",
               bus.wea, bus.addra, bus.dina, bus.done, bus.err, bus.rd_dly);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.busy, bus.cmd_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL reset_release: busy=%b cmd_ready=%b, want busy=0 cmd_ready=1", bus.busy, bus.cmd_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_write();
    logic [EW-1:0] e = 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_5678;
    bus.hold_entry = e; bus.hold_entry_no = 16'd5; bus.hold_way = 8'd2;
    bus.cmd = 2'd0; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.hold_entry = ~e;
    n_cmp++;
    if ({bus.wea, bus.addra, bus.dina} !== {4'b0100, AW'(5), e}) begin
      n_bad++;
      $display("FAIL write_c1: wea=%b addra=%0d dina=%h, want wea=0100 addra=5 dina=%h",
               bus.wea, bus.addra, bus.dina, e);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.err, bus.wea, bus.cmd_ready} !== {1'b1, 1'b0, 4'b0000, 1'b0}) begin
      n_bad++;
      $display("FAIL write_c2: done=%b err=%b wea=%b cmd_ready=%b, want 1 0 0000 0",
               bus.done, bus.err, bus.wea, bus.cmd_ready);
    end
    // Row stays at 5 in IDLE, so rd_dly may only rise LAT cycles after completion
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.cmd_ready, bus.done, bus.rd_dly} !== {1'b1, 1'b0, k > LAT}) begin
        n_bad++;
        $display("FAIL write_after_%0d: cmd_ready=%b done=%b rd_dly=%b, want 1 0 %b",
                 k, bus.cmd_ready, bus.done, bus.rd_dly, k > LAT);
      end
    end
  endtask

  task automatic test_replacement();
    int waited = 0;
    while ((m_lfsr % 4) != 3 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if ((m_lfsr % 4) != 3) begin
      n_cmp++; n_bad++;
      $display("FAIL replacement_wait: lfsr low bits never 3 within %0d cycles, got %h", waited, m_lfsr);
    end else begin
      bus.hold_entry = {4{$urandom}}; bus.hold_entry_no = 16'd11; bus.hold_way = 8'hFF;
      bus.cmd = 2'd0; bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      n_cmp++;
      if ({bus.wea, bus.addra} !== {4'b1000, AW'(11)}) begin
        n_bad++;
        $display("FAIL replacement: wea=%b addra=%0d, want wea=1000 addra=11", bus.wea, bus.addra);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_invalidate();
    logic [ASSOC-1:0] want;
    for (int i = 0; i < 2; i++) begin
      bus.hold_entry = {4{$urandom}} | 128'd1; bus.hold_entry_no = 16'd7;
      bus.hold_way = (i == 0) ? 8'd1 : 8'h10;
      want = (i == 0) ? 4'b0010 : 4'b1111;
      bus.cmd = 2'd1; bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      n_cmp++;
      if ({bus.wea, bus.addra, bus.dina} !== {want, AW'(7), {EW{1'b0}}}) begin
        n_bad++;
        $display("FAIL invalidate_%0d: wea=%b addra=%0d dina=%h, want wea=%b addra=7 dina=0",
                 i, bus.wea, bus.addra, bus.dina, want);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_errors();
    for (int i = 0; i < 2; i++) begin
      bus.hold_entry_no = (i == 0) ? 16'(ENTRIES) : 16'd3;
      bus.cmd = (i == 0) ? 2'd0 : 2'd3;
      bus.hold_way = 8'd0; bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      n_cmp++;
      if ({bus.done, bus.err, bus.wea} !== {1'b1, 1'b1, 4'b0000}) begin
        n_bad++;
        $display("FAIL error_%0d_c1: done=%b err=%b wea=%b, want 1 1 0000", i, bus.done, bus.err, bus.wea);
      end
      @(negedge clk);
      n_cmp++;
      if ({bus.done, bus.err, bus.busy, bus.wea} !== {1'b0, 1'b0, 1'b0, 4'b0000}) begin
        n_bad++;
        $display("FAIL error_%0d_c2: done=%b err=%b busy=%b wea=%b, want 0 0 0 0000",
                 i, bus.done, bus.err, bus.busy, bus.wea);
      end
    end
  endtask

  task automatic test_sweep();
    int bad_rows = 0;
    int idle_busy = 0;
    bus.hold_entry_no = 16'd2; bus.cmd = 2'd2; bus.cmd_valid = 1'b1;
    for (int k = 1; k <= ENTRIES; k++) begin
      @(negedge clk);
      // Stray requests during the sweep must be dropped
      bus.cmd_valid = (k < ENTRIES - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.cmd = 2'd0;
      if ({bus.wea, bus.addra, bus.dina, bus.cmd_ready, bus.done} !==
          {{ASSOC{1'b1}}, AW'(k - 1), {EW{1'b0}}, 1'b0, 1'b0}) begin
        bad_rows++;
        $display("FAIL sweep_row_%0d: wea=%b addra=%0d cmd_ready=%b done=%b, want 1111 %0d 0 0",
                 k, bus.wea, bus.addra, bus.cmd_ready, bus.done, k - 1);
      end
    end
    n_cmp++;
    if (bad_rows != 0) n_bad++;
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.err, bus.wea, bus.cmd_ready} !== {1'b1, 1'b0, 4'b0000, 1'b0}) begin
      n_bad++;
      $display("FAIL sweep_done: done=%b err=%b wea=%b cmd_ready=%b, want 1 0 0000 0",
               bus.done, bus.err, bus.wea, bus.cmd_ready);
    end
    repeat (3) begin
      @(negedge clk);
      if (bus.busy) idle_busy++;
    end
    n_cmp++;
    if (idle_busy != 0) begin
      n_bad++;
      $display("FAIL sweep_no_queue: busy for %0d cycles after sweep, want 0", idle_busy);
    end
  endtask

  task automatic test_rd_dly();
    logic [15:0] cur = 16'd3;
    logic [15:0] nxt;
    int hold;
    bus.hold_entry_no = cur;
    repeat (LAT + 2) @(negedge clk);
    n_cmp++;
    if (bus.rd_dly !== 1'b1) begin
      n_bad++;
      $display("FAIL rd_dly_settled: rd_dly=%b, want 1", bus.rd_dly);
    end
    for (int it = 0; it < 6; it++) begin
      nxt = (it == 0) ? 16'd9 : 16'($urandom_range(0, ENTRIES - 1));
      if (nxt == cur) nxt = 16'((cur + 1) % ENTRIES);
      cur = nxt;
      bus.hold_entry_no = cur;
      hold = (it == 0) ? LAT + 2 : $urandom_range(1, LAT + 2);
      for (int k = 1; k <= hold; k++) begin
        @(negedge clk);
        n_cmp++;
        if ({bus.rd_dly, bus.addra} !== {k > LAT, cur[AW-1:0]}) begin
          n_bad++;
          $display("FAIL rd_dly_%0d_%0d: rd_dly=%b addra=%0d, want %b %0d",
                   it, k, bus.rd_dly, bus.addra, k > LAT, cur);
        end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int dn = 0;
    int bsy = 0;
    bus.cmd = 2'd2; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({bus.wea, bus.addra} !== {{ASSOC{1'b1}}, AW'(6)}) begin
      n_bad++;
      $display("FAIL mid_sweep_row6: wea=%b addra=%0d, want 1111 6", bus.wea, bus.addra);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.wea, bus.busy, bus.cmd_ready, bus.done} !== {4'b0000, 1'b0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL mid_sweep_reset: wea=%b busy=%b cmd_ready=%b done=%b, want 0000 0 1 0",
               bus.wea, bus.busy, bus.cmd_ready, bus.done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) dn++;
      if (bus.busy) bsy++;
    end
    n_cmp++;
    if (dn != 0 || bsy != 0) begin
      n_bad++;
      $display("FAIL mid_sweep_after: done pulses=%0d busy cycles=%0d, want 0 0", dn, bsy);
    end
  endtask

  task automatic test_random();
    int c, no, way, r, elat, lat;
    logic rej;
    logic [EW-1:0] e, ed;
    logic [ASSOC-1:0] ew;
    logic [AW-1:0] ea;
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      c = (r < 5) ? 0 : (r < 8) ? 1 : (r == 8) ? 3 : 2;
      no = $urandom_range(0, ENTRIES + 3);
      way = $urandom_range(0, 1) ? $urandom_range(0, ASSOC - 1) : $urandom_range(ASSOC, 255);
      e = {$urandom, $urandom, $urandom, $urandom};
      bus.hold_entry = e; bus.hold_entry_no = 16'(no); bus.hold_way = 8'(way);
      bus.cmd = 2'(c); bus.cmd_valid = 1'b1;
      rej  = (c == 3) || (c < 2 && no >= ENTRIES);
      ew   = exp_wea(c, no, way, m_lfsr);
      ed   = (c == 0) ? e : '0;
      ea   = (c == 2) ? '0 : AW'(no);
      elat = rej ? 1 : (c == 2) ? ENTRIES + 1 : 2;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.hold_entry = ~e; bus.hold_way = 8'($urandom); bus.cmd = 2'($urandom);
      n_cmp++;
      if (bus.wea !== ew || (!rej && {bus.addra, bus.dina} !== {ea, ed})) begin
        n_bad++;
        $display("FAIL rand_%0d_c1 cmd=%0d no=%0d way=%0d: wea=%b addra=%0d dina=%h, want wea=%b addra=%0d dina=%h",
                 it, c, no, way, bus.wea, bus.addra, bus.dina, ew, ea, ed);
      end
      lat = 1;
      while (bus.done !== 1'b1 && lat < ENTRIES + 4) begin
        @(negedge clk);
        lat++;
      end
      n_cmp++;
      if (bus.done !== 1'b1 || lat != elat || bus.err !== rej) begin
        n_bad++;
        $display("FAIL rand_%0d_done cmd=%0d: done=%b latency=%0d err=%b, want 1 %0d %b",
                 it, c, bus.done, lat, bus.err, elat, rej);
      end
      @(negedge clk);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_replacement();
    test_invalidate();
    test_errors();
    test_sweep();
    test_rd_dly();
    test_reset_mid_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, compared=%0d mismatched=%0d", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
